// File: rtl/mem_arbiter.sv
// Two-core round-robin arbiter in front of a single-ported memory.
// One transaction at a time: IDLE grants, ACCESS waits for mem_ready, DONE pulses the ack.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_ack,

  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_ack,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              grant_id,
  output logic              busy,
  output logic [15:0]       c0_grants,
  output logic [15:0]       c1_grants
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic              mem_req_q, mem_req_d;
  cmd_t              cmd_q, cmd_d;
  logic              c0_ack_q, c0_ack_d;
  logic              c1_ack_q, c1_ack_d;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d;
  logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d;
  logic [15:0]       c0_grants_q, c0_grants_d;
  logic [15:0]       c1_grants_q, c1_grants_d;

  logic any_req;
  logic winner;
  cmd_t winner_cmd;

  // Round-robin: on a tie the core that did not win last time gets the port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_req    = c0_req | c1_req;
    winner     = 1'b0;
    winner_cmd = '{we: c0_we, addr: c0_addr, wdata: c0_wdata};
    if (c0_req && c1_req) begin
      winner = ~last_grant_q;
    end else begin
      winner = c1_req;
    end
    if (winner) begin
      winner_cmd = '{we: c1_we, addr: c1_addr, wdata: c1_wdata};
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_req_d    = mem_req_q;
    cmd_d        = cmd_q;
    c0_ack_d     = 1'b0;
    c1_ack_d     = 1'b0;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    c0_grants_d  = c0_grants_q;
    c1_grants_d  = c1_grants_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_ACCESS;
          grant_id_d = winner;
          mem_req_d  = 1'b1;
          cmd_d      = winner_cmd;
        end
      end

      ST_ACCESS: begin
        // The latched command stays put until memory completes; core inputs are ignored here.
        if (mem_req_q && mem_ready) begin
          state_d      = ST_DONE;
          mem_req_d    = 1'b0;
          last_grant_d = grant_id_q;
          if (grant_id_q) begin
            c1_ack_d    = 1'b1;
            c1_grants_d = c1_grants_q + 16'd1;
            if (!cmd_q.we) begin
              c1_rdata_d = mem_rdata;
            end
          end else begin
            c0_ack_d    = 1'b1;
            c0_grants_d = c0_grants_q + 16'd1;
            if (!cmd_q.we) begin
              c0_rdata_d = mem_rdata;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register, data included, because read data and counters are architecturally visible.
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      cmd_q        <= '0;
      c0_ack_q     <= 1'b0;
      c1_ack_q     <= 1'b0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
      c0_grants_q  <= '0;
      c1_grants_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_req_q    <= mem_req_d;
      cmd_q        <= cmd_d;
      c0_ack_q     <= c0_ack_d;
      c1_ack_q     <= c1_ack_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      c0_grants_q  <= c0_grants_d;
      c1_grants_q  <= c1_grants_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign c0_ack    = c0_ack_q;
  assign c1_ack    = c1_ack_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;
  assign c0_grants = c0_grants_q;
  assign c1_grants = c1_grants_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random transactions, checked every cycle
// against a transaction-level model (winner choice, per-core counters and read data).
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              c0_req, c0_we, c1_req, c1_we;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [DATA_W-1:0] c0_wdata, c1_wdata;
  logic [DATA_W-1:0] c0_rdata, c1_rdata;
  logic              c0_ack, c1_ack;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              grant_id, busy;
  logic [15:0]       c0_grants, c1_grants;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .c0_grants(c0_grants), .c1_grants(c1_grants)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: who won last, completed counts, last read data per core.
  logic              m_last;
  logic [15:0]       m_cnt   [2];
  logic [DATA_W-1:0] m_rdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_cnt[0]   = 16'd0;
    m_cnt[1]   = 16'd0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic check_cores(input string tag, input logic a0, input logic a1);
    check({tag, ".c0_ack"},    32'(c0_ack),    32'(a0));
    check({tag, ".c1_ack"},    32'(c1_ack),    32'(a1));
    check({tag, ".c0_rdata"},  c0_rdata,       m_rdata[0]);
    check({tag, ".c1_rdata"},  c1_rdata,       m_rdata[1]);
    check({tag, ".c0_grants"}, 32'(c0_grants), 32'(m_cnt[0]));
    check({tag, ".c1_grants"}, 32'(c1_grants), 32'(m_cnt[1]));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".busy"},      32'(busy),     32'd0);
    check({tag, ".mem_req"},   32'(mem_req),  32'd0);
    check({tag, ".mem_we"},    32'(mem_we),   32'd0);
    check({tag, ".mem_addr"},  mem_addr,      32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,     32'd0);
    check({tag, ".grant_id"},  32'(grant_id), 32'd0);
    check_cores(tag, 1'b0, 1'b0);
  endtask

  // Called at a negedge while the DUT is idle. Runs one full transaction (or one idle
  // cycle if nobody requests) and checks every cycle. 'scramble' perturbs the winner's
  // inputs during ACCESS, which must not reach the memory port.
  task automatic do_txn(input string tag, input logic r0, input logic r1,
                        input logic we0, input logic we1,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input int waits, input logic [DATA_W-1:0] rd, input bit scramble);
    logic              w;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    c0_req = r0; c0_we = we0; c0_addr = a0; c0_wdata = d0;
    c1_req = r1; c1_we = we1; c1_addr = a1; c1_wdata = d1;
    mem_ready = 1'($urandom_range(1, 0));
    mem_rdata = $urandom;
    if (!r0 && !r1) begin
      @(negedge clk);
      check({tag, ".idle_busy"},    32'(busy),    32'd0);
      check({tag, ".idle_mem_req"}, 32'(mem_req), 32'd0);
      check_cores({tag, ".idle"}, 1'b0, 1'b0);
    end else begin
      w      = (r0 && r1) ? ~m_last : r1;
      e_we   = w ? we1 : we0;
      e_addr = w ? a1 : a0;
      e_wd   = w ? d1 : d0;
      @(negedge clk);
      for (int i = 0; i <= waits; i++) begin
        check({tag, ".acc_busy"},      32'(busy),     32'd1);
        check({tag, ".acc_grant_id"},  32'(grant_id), 32'(w));
        check({tag, ".acc_mem_req"},   32'(mem_req),  32'd1);
        check({tag, ".acc_mem_we"},    32'(mem_we),   32'(e_we));
        check({tag, ".acc_mem_addr"},  mem_addr,      e_addr);
        check({tag, ".acc_mem_wdata"}, mem_wdata,     e_wd);
        check_cores({tag, ".acc"}, 1'b0, 1'b0);
        if (scramble && $urandom_range(1, 0) == 1) begin
          if (w) begin
            c1_req = 1'($urandom_range(1, 0)); c1_we = 1'($urandom_range(1, 0));
            c1_addr = $urandom; c1_wdata = $urandom;
          end else begin
            c0_req = 1'($urandom_range(1, 0)); c0_we = 1'($urandom_range(1, 0));
            c0_addr = $urandom; c0_wdata = $urandom;
          end
        end
        mem_ready = (i == waits);
        mem_rdata = (i == waits) ? rd : $urandom;
        @(negedge clk);
      end
      m_cnt[w] = m_cnt[w] + 16'd1;
      if (!e_we) m_rdata[w] = rd;
      m_last = w;
      check({tag, ".done_busy"},     32'(busy),     32'd1);
      check({tag, ".done_mem_req"},  32'(mem_req),  32'd0);
      check({tag, ".done_grant_id"}, 32'(grant_id), 32'(w));
      check_cores({tag, ".done"}, ~w, w);
      mem_ready = 1'($urandom_range(1, 0));
      mem_rdata = $urandom;
      @(negedge clk);
      check({tag, ".post_busy"},    32'(busy),    32'd0);
      check({tag, ".post_mem_req"}, 32'(mem_req), 32'd0);
      check_cores({tag, ".post"}, 1'b0, 1'b0);
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("reset");

    // Lone c0 read, one wait cycle.
    do_txn("c0_read", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 1, 32'h0000000F, 1'b0);
    check("c0_read.rdata15", c0_rdata, 32'h0000000F);
    check("c0_read.grants1", 32'(c0_grants), 32'd1);

    // Tie right after reset: core0 first, then core1.
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    check_reset_state("reset2");
    do_txn("tie_first", 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 0, 32'hA5A5_0001, 1'b0);
    do_txn("tie_second", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0, 0, 32'hA5A5_0002, 1'b0);
    check("tie.c0_rdata", c0_rdata, 32'hA5A5_0001);
    check("tie.c1_rdata", c1_rdata, 32'hA5A5_0002);

    // Continuous contention: strict alternation, 3 each.
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    for (int k = 0; k < 6; k++) begin
      do_txn("fair", 1'b1, 1'b1, 1'b0, 1'b1, 32'h40 + 32'(k), 32'h80 + 32'(k),
             32'h0, 32'hF0 + 32'(k), 0, $urandom, 1'b0);
    end
    check("fair.c0_grants3", 32'(c0_grants), 32'd3);
    check("fair.c1_grants3", 32'(c1_grants), 32'd3);

    // c1 write with a 4-cycle memory stall; fields change underneath.
    do_txn("c1_write", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'h1B, 4, 32'hDEAD_0000, 1'b1);

    // Reset during the second ACCESS cycle abandons the transaction.
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h300; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_acc.mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBEEF_CAFE; c0_req = 1'b1;
    @(negedge clk);
    rst = 1'b0; c0_req = 1'b0; c1_req = 1'b0; mem_ready = 1'b0;
    model_reset();
    check_reset_state("rst_acc");
    do_txn("rst_tie", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 0, 32'h1234_5678, 1'b0);

    // Counter wrap: preload 0xFFFF, then one more c0 completion.
    force dut.c0_grants_q = 16'hFFFF;
    #1;
    release dut.c0_grants_q;
    m_cnt[0] = 16'hFFFF;
    do_txn("wrap", 1'b1, 1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 32'h77, 32'h0, 0, 32'h0, 1'b0);
    check("wrap.c0_grants0", 32'(c0_grants), 32'd0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      do_txn("rand", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(3, 0)), $urandom, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
